// File: rtl/profiling_pkg.sv
// Shared definitions for the stream profiling controller: FSM state encoding
// and the width of the packet sequence number.
package profiling_pkg;

  localparam int SEQUENCE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_TERMINATE = 3'd3,
    ST_REPORT    = 3'd4
  } state_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear has priority
// over increment so a new run always starts from zero.
module saturating_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_value <= '0;
    end else if (increment && (r_value != '1)) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/stream_profiling_controller.sv
// Gates the processor enable, passes ingress/egress streams through and
// profiles each packet; a timed-out run is closed with a synthetic last beat.
module stream_profiling_controller
  import profiling_pkg::*;
#(
  parameter int          DATA_IN_SIZE   = 8,
  parameter int          DATA_OUT_SIZE  = 8,
  parameter int          COUNTER_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic [DATA_IN_SIZE-1:0]   data_ingress_in,
  input  logic                      valid_ingress_in,
  output logic                      ready_ingress_in,
  input  logic                      last_ingress_in,

  output logic [DATA_IN_SIZE-1:0]   data_ingress_out,
  output logic                      valid_ingress_out,
  input  logic                      ready_ingress_out,
  output logic                      last_ingress_out,

  output logic                      enable,

  input  logic [DATA_OUT_SIZE-1:0]  data_egress_in,
  input  logic                      valid_egress_in,
  output logic                      ready_egress_in,
  input  logic                      last_egress_in,

  output logic [DATA_OUT_SIZE-1:0]  data_egress_out,
  output logic                      valid_egress_out,
  input  logic                      ready_egress_out,
  output logic                      last_egress_out,

  output logic [COUNTER_WIDTH-1:0]  clock_cycles,
  output logic [COUNTER_WIDTH-1:0]  stall_cycles,
  output logic                      timed_out,
  output logic [SEQUENCE_WIDTH-1:0] sequence_number,
  output logic                      report_valid,
  input  logic                      report_ready
);

  // One spare bit so the "next count" never overflows before the compare.
  localparam int CMP_W = (COUNTER_WIDTH >= 32) ? COUNTER_WIDTH + 1 : 33;

  state_t                    r_state;
  logic                      r_ingressClosed;
  logic                      r_timedOut;
  logic [SEQUENCE_WIDTH-1:0] r_sequence;

  logic                      w_inRun;
  logic                      w_enterRun;
  logic                      w_ingressLastAccept;
  logic                      w_egressLastAccept;
  logic                      w_flushLastAccept;
  logic                      w_stallIncrement;
  logic                      w_timeoutHit;
  logic [COUNTER_WIDTH-1:0]  w_clockCycles;
  logic [COUNTER_WIDTH-1:0]  w_stallCycles;
  logic [CMP_W-1:0]          w_cyclesNext;

  assign w_inRun             = (r_state == ST_RUN);
  assign w_enterRun          = (r_state == ST_IDLE) && valid_ingress_in;
  assign w_ingressLastAccept = w_inRun && !r_ingressClosed && valid_ingress_in
                               && ready_ingress_out && last_ingress_in;
  assign w_egressLastAccept  = w_inRun && valid_egress_in && ready_egress_out
                               && last_egress_in;
  assign w_flushLastAccept   = (r_state == ST_FLUSH) && valid_ingress_in && last_ingress_in;
  assign w_stallIncrement    = w_inRun && valid_egress_in && !ready_egress_out;

  // The timeout fires on the RUN cycle whose increment brings the count to the limit.
  assign w_cyclesNext = CMP_W'(w_clockCycles) + CMP_W'(1);
  assign w_timeoutHit = (TIMEOUT_CYCLES != 0) && w_inRun
                        && (w_cyclesNext == CMP_W'(TIMEOUT_CYCLES));

  saturating_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_cycleCounter (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_enterRun),
    .increment(w_inRun),
    .value    (w_clockCycles)
  );

  saturating_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_stallCounter (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_enterRun),
    .increment(w_stallIncrement),
    .value    (w_stallCycles)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_ingressClosed <= 1'b0;
      r_timedOut      <= 1'b0;
      r_sequence      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_ingress_in) begin
            r_state         <= ST_RUN;
            r_ingressClosed <= 1'b0;
            r_timedOut      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_ingressLastAccept) begin
            r_ingressClosed <= 1'b1;
          end
          // A real egress last beats a coincident timeout.
          if (w_egressLastAccept) begin
            r_state <= ST_REPORT;
          end else if (w_timeoutHit) begin
            r_timedOut <= 1'b1;
            r_state    <= (r_ingressClosed || w_ingressLastAccept) ? ST_TERMINATE : ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_flushLastAccept) begin
            r_state <= ST_TERMINATE;
          end
        end
        ST_TERMINATE: begin
          if (ready_egress_out) begin
            r_state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            r_state    <= ST_IDLE;
            r_sequence <= r_sequence + SEQUENCE_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    enable            = 1'b0;
    ready_ingress_in  = 1'b0;
    valid_ingress_out = 1'b0;
    data_ingress_out  = '0;
    last_ingress_out  = 1'b0;
    ready_egress_in   = 1'b0;
    valid_egress_out  = 1'b0;
    data_egress_out   = '0;
    last_egress_out   = 1'b0;
    report_valid      = 1'b0;
    case (r_state)
      ST_RUN: begin
        enable = 1'b1;
        if (!r_ingressClosed) begin
          ready_ingress_in  = ready_ingress_out;
          valid_ingress_out = valid_ingress_in;
          data_ingress_out  = data_ingress_in;
          last_ingress_out  = last_ingress_in;
        end
        ready_egress_in  = ready_egress_out;
        valid_egress_out = valid_egress_in;
        data_egress_out  = data_egress_in;
        last_egress_out  = last_egress_in;
      end
      // Upstream is drained so the collector never blocks on a dead run.
      ST_FLUSH: begin
        ready_ingress_in = 1'b1;
      end
      ST_TERMINATE: begin
        valid_egress_out = 1'b1;
        last_egress_out  = 1'b1;
      end
      ST_REPORT: begin
        report_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign clock_cycles    = w_clockCycles;
  assign stall_cycles    = w_stallCycles;
  assign timed_out       = r_timedOut;
  assign sequence_number = r_sequence;

endmodule
